// File: rtl/reg_bus_master.sv
// Register-bus initiator: takes one read/write command at a time, drives the
// sel/wr/addr/wdata bus, collects read data and returns one response per command.
module reg_bus_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready
);

  // A zero-width counter is not legal, so TIMEOUT=0 keeps a 1-bit dummy.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    sel_next, wr_next, rsp_valid_next, rsp_err_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   wdata_next, rsp_rdata_next;
  logic                    stall, abort;

  assign cmd_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sel       <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel       <= sel_next;
      wr        <= wr_next;
      addr      <= addr_next;
      wdata     <= wdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sel_next       = sel;
    wr_next        = wr;
    addr_next      = addr;
    wdata_next     = wdata;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    stall          = 1'b0;
    abort          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          wr_next    = cmd_wr;
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          sel_next   = 1'b1;
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ready && wr) begin
          sel_next       = 1'b0;
          wr_next        = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (ready) begin
          sel_next   = 1'b0;
          cnt_next   = '0;
          state_next = WAIT_RD;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_RD: begin
        if (ready) begin
          rsp_rdata_next = rdata;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          stall = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A ready=1 edge never reaches here, so completion always beats expiry.
    if (stall && TO_EN) begin
      if (cnt_reg == CNT_LAST) abort = 1'b1;
      else cnt_next = cnt_reg + CW'(1);
    end

    if (abort) begin
      sel_next       = 1'b0;
      wr_next        = 1'b0;
      rsp_rdata_next = '0;
      rsp_err_next   = 1'b1;
      rsp_valid_next = 1'b1;
      state_next     = RESP;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a TIMEOUT=4 instance for the main tests and a
// TIMEOUT=0 instance for the unbounded wait; responses are checked by scoreboards.
module tb_reg_bus_master;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance a: TIMEOUT=4
  logic        cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready, rsp_err;
  logic        sel, wr, ready;
  logic [7:0]  cmd_addr, addr;
  logic [15:0] cmd_wdata, rsp_rdata, wdata, rdata;

  // Instance b: TIMEOUT=0
  logic        b_cmd_valid, b_cmd_ready, b_cmd_wr, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic        b_sel, b_wr, b_ready;
  logic [7:0]  b_cmd_addr, b_addr;
  logic [15:0] b_cmd_wdata, b_rsp_rdata, b_wdata, b_rdata;

  reg_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  reg_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(b_cmd_wr),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .sel(b_sel), .wr(b_wr), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [16:0] qa[$];
  logic [16:0] qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    total_cnt++;
    $display("FAIL %s: wait bound expired got none expected event at %0t", name, $time);
  endtask

  // Scoreboard monitors: one pop per response handshake.
  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (qa.size() == 0) timeout_fail("a unexpected response");
      else check("a rsp {err,rdata}", {15'd0, rsp_err, rsp_rdata}, {15'd0, qa.pop_front()});
      $display("rsp a: err=%0d rdata=0x%04h", rsp_err, rsp_rdata);
    end
  end

  always @(negedge clk) begin
    if (rstn && b_rsp_valid && b_rsp_ready) begin
      if (qb.size() == 0) timeout_fail("b unexpected response");
      else check("b rsp {err,rdata}", {15'd0, b_rsp_err, b_rsp_rdata}, {15'd0, qb.pop_front()});
      $display("rsp b: err=%0d rdata=0x%04h", b_rsp_err, b_rsp_rdata);
    end
  end

  // Call just after a rising edge; returns 1ns after the accept edge t0.
  task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    cmd_wr = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timeout_fail("cmd accept");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    $display("cmd a: wr=%0d addr=0x%02h wdata=0x%04h", w, a, d);
  endtask

  task automatic align(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 1; ready = 1; rdata = 0;
    b_cmd_valid = 0; b_cmd_wr = 0; b_cmd_addr = 0; b_cmd_wdata = 0;
    b_rsp_ready = 1; b_ready = 1; b_rdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset sel", {31'd0, sel}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset addr", {24'd0, addr}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Write with ready tied high
    qa.push_back({1'b0, 16'h0000});
    issue(1'b1, 8'hbe, 16'hbc7a);
    @(negedge clk);
    check("wr sel", {31'd0, sel}, 32'd1);
    check("wr addr", {24'd0, addr}, 32'h0be);
    check("wr wr", {31'd0, wr}, 32'd1);
    check("wr wdata", {16'd0, wdata}, 32'hbc7a);
    check("wr cmd_ready busy", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("wr sel one cycle", {31'd0, sel}, 32'd0);
    check("wr rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // Read with one stalled edge in REQ
    align(2);
    qa.push_back({1'b0, 16'h1234});
    issue(1'b0, 8'h57, 16'h0000);
    ready = 1'b0; rdata = 16'h1234;
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rd rsp_valid early", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rd rsp_valid t0+3", {31'd0, rsp_valid}, 32'd1);

    // Timeout with ready stuck low, then a healthy read
    align(2);
    ready = 1'b0;
    qa.push_back({1'b1, 16'h0000});
    issue(1'b1, 8'ha9, 16'h1111);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("to sel held", {31'd0, sel}, 32'd1);
    end
    @(posedge clk); @(negedge clk);
    check("to sel dropped", {31'd0, sel}, 32'd0);
    check("to wr dropped", {31'd0, wr}, 32'd0);
    check("to rsp_valid", {31'd0, rsp_valid}, 32'd1);
    align(2);
    ready = 1'b1; rdata = 16'h00aa;
    qa.push_back({1'b0, 16'h00aa});
    issue(1'b0, 8'h10, 16'h0000);

    // Back-pressure on the response, with a stray command while busy
    align(4);
    rsp_ready = 1'b0; rdata = 16'h3d4c;
    qa.push_back({1'b0, 16'h3d4c});
    issue(1'b0, 8'h22, 16'h0000);
    @(posedge clk); @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'hff;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp rsp_rdata", {16'd0, rsp_rdata}, 32'h3d4c);
      check("bp cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp addr stable", {24'd0, addr}, 32'h22);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp released rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp released cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset in WAIT_RD discards the pending read
    align(2);
    issue(1'b0, 8'h57, 16'h0000);
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    check("rst pre cmd_ready", {31'd0, cmd_ready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("rst sel", {31'd0, sel}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    ready = 1'b1;
    align(3);
    rstn = 1'b1;
    check("rst no pending", qa.size(), 32'd0);
    qa.push_back({1'b0, 16'h0000});
    issue(1'b1, 8'h3e, 16'h27bd);
    @(negedge clk);
    check("post-rst addr", {24'd0, addr}, 32'h3e);
    check("post-rst wdata", {16'd0, wdata}, 32'h27bd);

    n = 0;
    while (qa.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0) timeout_fail("a drain");

    // TIMEOUT=0 instance: 100 stalled edges in WAIT_RD, no abort
    align(1);
    qb.push_back({1'b0, 16'h1234});
    b_cmd_wr = 1'b0; b_cmd_addr = 8'h57; b_cmd_valid = 1'b1;
    @(posedge clk);
    #1 b_cmd_valid = 1'b0;
    $display("cmd b: wr=0 addr=0x57");
    @(posedge clk);
    #1 b_ready = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("b no abort rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    check("b waiting cmd_ready", {31'd0, b_cmd_ready}, 32'd0);
    b_ready = 1'b1; b_rdata = 16'h1234;
    n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (qb.size() != 0) timeout_fail("b drain");

    align(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
